stopwatch_timer_core: RTL and testbench

//  Parametrised successor of the fixed 99:59:99 stopwatch counter. Counts mins:secs:centisecs
//  up (stopwatch) or down (countdown timer) from a CLK_100Hz-derived tick. Adds run/pause,

---
 rtl/stopwatch_timer_core_pkg.sv | 14 +
 rtl/stopwatch_timer_core_if.sv | 33 +++
 rtl/stopwatch_timer_core_digit_counter.sv | 42 ++++
 rtl/stopwatch_timer_core.sv | 155 +++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_timer_core_pkg.sv
// Shared types and field geometry for the stopwatch/countdown timer core.
package stopwatch_timer_core_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} sw_state_e;

  localparam int unsigned CsW  = 7;
  localparam int unsigned SecW = 6;
  localparam int unsigned MinW = 7;

  localparam int unsigned DefCsMax  = 99;
  localparam int unsigned DefSecMax = 59;
  localparam int unsigned DefMinMax = 99;

endpackage

// File: rtl/stopwatch_timer_core_if.sv
// Control pulses, preload values and display/status outputs of the timer core.
interface stopwatch_timer_core_if;
  import stopwatch_timer_core_pkg::*;

  logic            start_stop;
  logic            clear;
  logic            lap;
  logic            mode_down;
  logic            load;
  logic [MinW-1:0] load_mins;
  logic [SecW-1:0] load_secs;

  logic [MinW-1:0] stopwatch_unit_mins;
  logic [SecW-1:0] stopwatch_unit_secs;
  logic [CsW-1:0]  stopwatch_unit_decs;
  logic            running;
  logic            lap_active;
  logic            stopwatch_overflow;
  logic            expired;

  modport master (
    output start_stop, clear, lap, mode_down, load, load_mins, load_secs,
    input  stopwatch_unit_mins, stopwatch_unit_secs, stopwatch_unit_decs,
    input  running, lap_active, stopwatch_overflow, expired
  );

  modport slave (
    input  start_stop, clear, lap, mode_down, load, load_mins, load_secs,
    output stopwatch_unit_mins, stopwatch_unit_secs, stopwatch_unit_decs,
    output running, lap_active, stopwatch_overflow, expired
  );

endinterface

// File: rtl/stopwatch_timer_core_digit_counter.sv
// Mod-(MAX+1) up/down digit with sync clear and load; tc_o flags the wrap value
// (MAX going up, 0 going down) independent of en_i so the parent can chain carries.
module stopwatch_timer_core_digit_counter #(
  parameter int unsigned MAX = 99,
  parameter int unsigned W   = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MaxV = W'(MAX);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      if (dir_i) q_d = (q_q == '0) ? MaxV : q_q - 1'b1;
      else       q_d = (q_q == MaxV) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o  = q_q;
  assign tc_o = dir_i ? (q_q == '0) : (q_q == MaxV);

endmodule

// File: rtl/stopwatch_timer_core.sv
// Min:sec:centisec stopwatch / countdown timer with run/pause, lap freeze, preload and
// selectable saturate-or-wrap overflow policy.
module stopwatch_timer_core
  import stopwatch_timer_core_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 1,
  parameter int unsigned CS_MAX       = DefCsMax,
  parameter int unsigned SEC_MAX      = DefSecMax,
  parameter int unsigned MIN_MAX      = DefMinMax,
  parameter bit          WRAP_ON_OVF  = 1'b0
) (
  input logic                   CLK_100Hz,
  input logic                   reset,
  stopwatch_timer_core_if.slave sw
);

  if (CLK_PER_TICK < 1) begin : g_chk_cpt
    $error("CLK_PER_TICK must be at least 1");
  end
  if ($clog2(CS_MAX + 1) > CsW || $clog2(SEC_MAX + 1) > SecW ||
      $clog2(MIN_MAX + 1) > MinW) begin : g_chk_width
    $error("CS_MAX/SEC_MAX/MIN_MAX do not fit the 7/6/7-bit fields");
  end

  localparam int unsigned    PsW     = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PsW-1:0] PsLast  = PsW'(CLK_PER_TICK - 1);
  localparam logic [SecW-1:0] SecMaxV = SecW'(SEC_MAX);
  localparam logic [MinW-1:0] MinMaxV = MinW'(MIN_MAX);
  localparam logic [CsW-1:0]  CsOne   = CsW'(1);

  sw_state_e       state_d, state_q;
  logic [PsW-1:0]  ps_d, ps_q;
  logic            dir_d, dir_q;
  logic            lap_d, lap_q;
  logic            ovf_d, ovf_q;
  logic            exp_d, exp_q;
  logic [CsW-1:0]  snap_cs_q;
  logic [SecW-1:0] snap_sec_q;
  logic [MinW-1:0] snap_min_q;

  logic [CsW-1:0]  cs_q;
  logic [SecW-1:0] sec_q;
  logic [MinW-1:0] min_q;
  logic            cs_tc, sec_tc, min_tc;
  logic            cs_en, sec_en, min_en;
  logic [SecW-1:0] load_sec;
  logic [MinW-1:0] load_min;

  logic in_run, in_active, tick, tick_go, load_go, start_go, lap_go;
  logic up_ovf, sat_hold, down_end, cnt_clr;

  assign in_run    = (state_q == StRun);
  assign in_active = in_run || (state_q == StPause);
  assign tick      = in_run && (ps_q == PsLast);
  assign tick_go   = tick && !sw.clear;
  assign load_go   = sw.load && !sw.clear && (state_q == StIdle);
  assign start_go  = sw.start_stop && !sw.clear && !load_go;
  assign lap_go    = sw.lap && !sw.clear && !sw.start_stop && in_active;

  assign up_ovf   = tick_go && !dir_q && cs_tc && sec_tc && min_tc;
  assign sat_hold = up_ovf && !WRAP_ON_OVF;
  // Next value is 00:00:00 (or already there): force zero instead of borrowing to max.
  assign down_end = tick_go && dir_q && sec_tc && min_tc && (cs_q <= CsOne);
  assign cnt_clr  = sw.clear || down_end;

  assign cs_en  = tick_go && !sat_hold;
  assign sec_en = cs_en && cs_tc;
  assign min_en = sec_en && sec_tc;

  assign load_sec = (sw.load_secs > SecMaxV) ? SecMaxV : sw.load_secs;
  assign load_min = (sw.load_mins > MinMaxV) ? MinMaxV : sw.load_mins;

  stopwatch_timer_core_digit_counter #(.MAX(CS_MAX), .W(CsW)) u_cs (
    .clk_i(CLK_100Hz), .rst_i(reset), .en_i(cs_en), .dir_i(dir_q), .clr_i(cnt_clr),
    .load_i(load_go), .load_val_i('0), .q_o(cs_q), .tc_o(cs_tc)
  );
  stopwatch_timer_core_digit_counter #(.MAX(SEC_MAX), .W(SecW)) u_sec (
    .clk_i(CLK_100Hz), .rst_i(reset), .en_i(sec_en), .dir_i(dir_q), .clr_i(cnt_clr),
    .load_i(load_go), .load_val_i(load_sec), .q_o(sec_q), .tc_o(sec_tc)
  );
  stopwatch_timer_core_digit_counter #(.MAX(MIN_MAX), .W(MinW)) u_min (
    .clk_i(CLK_100Hz), .rst_i(reset), .en_i(min_en), .dir_i(dir_q), .clr_i(cnt_clr),
    .load_i(load_go), .load_val_i(load_min), .q_o(min_q), .tc_o(min_tc)
  );

  always_comb begin
    state_d = state_q;
    if (sw.clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_go) state_d = StRun;
        StRun: begin
          if (down_end || sat_hold) state_d = StDone;
          else if (start_go)        state_d = StPause;
        end
        StPause: if (start_go) state_d = StRun;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ps_d = ps_q;
    if (sw.clear || !in_active) ps_d = '0;
    else if (in_run)            ps_d = tick ? '0 : ps_q + 1'b1;
    dir_d = (state_q == StIdle && start_go) ? sw.mode_down : dir_q;
    lap_d = sw.clear ? 1'b0 : (lap_go ? !lap_q : lap_q);
    ovf_d = sw.clear ? 1'b0 : (ovf_q || up_ovf);
    exp_d = down_end;
  end

  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ps_q    <= '0;
      dir_q   <= 1'b0;
      lap_q   <= 1'b0;
      ovf_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      dir_q   <= dir_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
      exp_q   <= exp_d;
    end
  end

  // Snapshot takes the pre-tick live value when a lap and a tick share an edge.
  always_ff @(posedge CLK_100Hz or posedge reset) begin
    if (reset) begin
      snap_cs_q  <= '0;
      snap_sec_q <= '0;
      snap_min_q <= '0;
    end else if (lap_go && !lap_q) begin
      snap_cs_q  <= cs_q;
      snap_sec_q <= sec_q;
      snap_min_q <= min_q;
    end
  end

  always_comb begin
    sw.running             = in_run;
    sw.lap_active          = lap_q;
    sw.stopwatch_overflow  = ovf_q;
    sw.expired             = exp_q;
    sw.stopwatch_unit_mins = lap_q ? snap_min_q : min_q;
    sw.stopwatch_unit_secs = lap_q ? snap_sec_q : sec_q;
    sw.stopwatch_unit_decs = lap_q ? snap_cs_q  : cs_q;
  end

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Drives two timer instances (1 clk/tick saturating, 4 clk/tick wrapping) with the same
// stimulus and scoreboards every cycle against a total-centisecond reference model.
module tb_stopwatch_timer_core;

  typedef struct packed {
    logic [6:0] m;
    logic [5:0] s;
    logic [6:0] c;
    logic       run;
    logic       lapa;
    logic       ovf;
    logic       exp;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } pair_t;

  localparam int SIdle = 0, SRun = 1, SPause = 2, SDone = 3;
  localparam int PerSec = 100, PerMin = 6000;
  localparam int MaxVal = 99 * PerMin + 59 * PerSec + 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0, clear = 1'b0, lap = 1'b0, mode_down = 1'b0, load = 1'b0;
  logic [6:0] load_mins = '0;
  logic [5:0] load_secs = '0;

  int total = 0;
  int bad   = 0;

  int m_st[2], m_val[2], m_ps[2], m_snap[2];
  bit m_dn[2], m_ovf[2], m_lap[2], m_exp[2];

  pair_t exp_q[$];
  pair_t mon_e;
  obs_t  obs0, obs1;

  stopwatch_timer_core_if swa ();
  stopwatch_timer_core_if swb ();

  assign swa.start_stop = start_stop;
  assign swa.clear      = clear;
  assign swa.lap        = lap;
  assign swa.mode_down  = mode_down;
  assign swa.load       = load;
  assign swa.load_mins  = load_mins;
  assign swa.load_secs  = load_secs;
  assign swb.start_stop = start_stop;
  assign swb.clear      = clear;
  assign swb.lap        = lap;
  assign swb.mode_down  = mode_down;
  assign swb.load       = load;
  assign swb.load_mins  = load_mins;
  assign swb.load_secs  = load_secs;

  stopwatch_timer_core #(.CLK_PER_TICK(1), .WRAP_ON_OVF(1'b0)) dut0 (
    .CLK_100Hz(clk), .reset(rst), .sw(swa.slave)
  );
  stopwatch_timer_core #(.CLK_PER_TICK(4), .WRAP_ON_OVF(1'b1)) dut1 (
    .CLK_100Hz(clk), .reset(rst), .sw(swb.slave)
  );

  assign obs0 = {swa.stopwatch_unit_mins, swa.stopwatch_unit_secs, swa.stopwatch_unit_decs,
                 swa.running, swa.lap_active, swa.stopwatch_overflow, swa.expired};
  assign obs1 = {swb.stopwatch_unit_mins, swb.stopwatch_unit_secs, swb.stopwatch_unit_decs,
                 swb.running, swb.lap_active, swb.stopwatch_overflow, swb.expired};

  always #5 clk = ~clk;

  function automatic void check_obs(string name, obs_t act, obs_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %0d:%0d:%0d run=%b lap=%b ovf=%b exp=%b, want %0d:%0d:%0d run=%b lap=%b ovf=%b exp=%b",
               name, $time, act.m, act.s, act.c, act.run, act.lapa, act.ovf, act.exp,
               want.m, want.s, want.c, want.run, want.lapa, want.ovf, want.exp);
    end
  endfunction

  function automatic void model_reset(int k);
    m_st[k] = SIdle; m_val[k] = 0; m_ps[k] = 0; m_snap[k] = 0;
    m_dn[k] = 1'b0; m_ovf[k] = 1'b0; m_lap[k] = 1'b0; m_exp[k] = 1'b0;
  endfunction

  // One clock edge of behaviour, written over a single total-centisecond value.
  function automatic void model_step(int k);
    int cpt, s0, lm, ls;
    bit wrap, tick;
    cpt  = (k == 0) ? 1 : 4;
    wrap = (k == 1);
    s0   = m_st[k];
    tick = (s0 == SRun) && (m_ps[k] == cpt - 1);
    m_exp[k] = 1'b0;
    if (clear) begin
      m_st[k] = SIdle; m_val[k] = 0; m_ps[k] = 0; m_ovf[k] = 1'b0; m_lap[k] = 1'b0;
      return;
    end
    if (s0 == SRun)         m_ps[k] = tick ? 0 : m_ps[k] + 1;
    else if (s0 != SPause)  m_ps[k] = 0;
    if (s0 == SIdle) begin
      if (load) begin
        lm = (int'(load_mins) > 99) ? 99 : int'(load_mins);
        ls = (int'(load_secs) > 59) ? 59 : int'(load_secs);
        m_val[k] = lm * PerMin + ls * PerSec;
      end else if (start_stop) begin
        m_st[k] = SRun;
        m_dn[k] = mode_down;
      end
      return;
    end
    if (lap && !start_stop && (s0 == SRun || s0 == SPause)) begin
      if (!m_lap[k]) m_snap[k] = m_val[k];
      m_lap[k] = !m_lap[k];
    end
    if (tick) begin
      if (!m_dn[k]) begin
        if (m_val[k] == MaxVal) begin
          m_ovf[k] = 1'b1;
          if (wrap) m_val[k] = 0;
          else      m_st[k] = SDone;
        end else begin
          m_val[k]++;
        end
      end else if (m_val[k] <= 1) begin
        m_val[k] = 0;
        m_exp[k] = 1'b1;
        m_st[k]  = SDone;
      end else begin
        m_val[k]--;
      end
    end
    if (start_stop) begin
      if (s0 == SRun && m_st[k] == SRun) m_st[k] = SPause;
      else if (s0 == SPause)             m_st[k] = SRun;
    end
  endfunction

  function automatic obs_t to_obs(int k);
    obs_t o;
    int   v;
    v      = m_lap[k] ? m_snap[k] : m_val[k];
    o.m    = 7'(v / PerMin);
    o.s    = 6'((v / PerSec) % 60);
    o.c    = 7'(v % PerSec);
    o.run  = (m_st[k] == SRun);
    o.lapa = m_lap[k];
    o.ovf  = m_ovf[k];
    o.exp  = m_exp[k];
    return o;
  endfunction

  task automatic step(input bit c, input bit ld, input bit ss, input bit lp);
    pair_t e;
    clear = c; load = ld; start_stop = ss; lap = lp;
    @(posedge clk);
    model_step(0);
    model_step(1);
    e.a = to_obs(0);
    e.b = to_obs(1);
    exp_q.push_back(e);
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start_stop = 1'b0; lap = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must drop immediately.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check_obs("async_reset0", obs0, '0);
    check_obs("async_reset1", obs1, '0);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_obs("cycle_inst0", obs0, mon_e.a);
      check_obs("cycle_inst1", obs1, mon_e.b);
    end
  end

  initial begin
    int guard;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check_obs("reset0", obs0, '0);
    check_obs("reset1", obs1, '0);
    #2 rst = 1'b0;
    @(negedge clk);
    idle(3);

    // Run to 00:05:37 then reset mid-cycle; must stay idle afterwards.
    step(0, 0, 1, 0);
    idle(537);
    mid_reset();
    idle(5);

    // Up-count to 01:00:00, then overflow from 99:59:99.
    step(0, 0, 1, 0);
    idle(6000);
    step(1, 0, 0, 0);
    load_mins = 7'd99; load_secs = 6'd59;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(420);
    step(0, 0, 1, 0);
    idle(3);
    step(1, 0, 0, 0);

    // Countdown from 00:02:00.
    load_mins = 7'd0; load_secs = 6'd2; mode_down = 1'b1;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(210);
    step(0, 0, 1, 0);
    idle(3);
    step(1, 0, 0, 0);
    mode_down = 1'b0;

    // Lap freeze at 00:10:25, release after 300 ticks.
    load_mins = 7'd0; load_secs = 6'd10;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    idle(25);
    step(0, 0, 0, 1);
    idle(300);
    step(0, 0, 0, 1);
    idle(5);
    step(1, 0, 0, 0);

    // Pause/resume, then clear on an edge where instance 1 would tick.
    step(0, 0, 1, 0);
    idle(10);
    step(0, 0, 1, 0);
    idle(50);
    step(0, 0, 1, 0);
    idle(30);
    guard = 0;
    while (m_ps[1] != 3 && guard < 8) begin
      step(0, 0, 0, 0);
      guard++;
    end
    step(1, 0, 0, 0);
    idle(2);

    // Clamped preload, then a load while running is ignored.
    load_mins = 7'd120; load_secs = 6'd63;
    step(0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    idle(3);
    load_mins = 7'd5; load_secs = 6'd5;
    step(0, 1, 0, 0);
    idle(5);
    step(0, 1, 1, 1);
    idle(5);
    step(1, 0, 0, 0);

    // Randomized pulses, including coincident ones.
    for (int i = 0; i < 5000; i++) begin
      bit c, ld, ss, lp;
      c  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 39) == 0);
      ss = ($urandom_range(0, 29) == 0);
      lp = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) == 0) mode_down = 1'($urandom_range(0, 1));
      load_mins = ($urandom_range(0, 19) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 1));
      load_secs = 6'($urandom_range(0, 63));
      step(c, ld, ss, lp);
    end

    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
